bcd_to_binary_seq: RTL
======================

Name: bcd_to_binary_seq

Overview:
Sequential BCD-to-binary converter. It is the inverse of the binary-to-BCD stage that feeds the seven-segment digits. It accepts a packed multi-digit BCD value, for example digits entered on the switches or keys, and converts it with a reverse double-dabble loop: shift right, then subtract 3 from any digit that is 8 or more. Results go to the game/score logic, which needs binary. It uses a start/busy/done handshake with fixed latency.

Parameters:
DIGITS, 3, number of BCD digits in bcd_in (digit 0 = ones, in bits [3:0]).
BIN_W, 10, output binary width. Requires 10^DIGITS-1 < 2^BIN_W. Also sets the iteration count.

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  conversion request; sampled only in IDLE.
bcd_in  input  4*DIGITS  packed BCD value; digit k in bits [4k+3:4k].
busy  output  1  high from the cycle after start is accepted until done is asserted.
done  output  1  one-cycle pulse; binary_out is valid in that cycle and stays valid after it.
err  output  1  invalid-digit flag (see Optional Feature).
binary_out  output  BIN_W  converted value.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset values: busy=0, done=0, err=0, binary_out=0, FSM=IDLE, iteration counter=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT when start=1:
  - Load bcd_in into the BCD shift register and clear the binary accumulator.
  - Load counter=BIN_W.
- SHIFT, one iteration per cycle:
  - Shift {bcd_reg, bin_acc} right by 1, so the bcd LSB enters the bin_acc MSB.
  - Then subtract 3 from every 4-bit digit of the new bcd_reg whose value is 8 or more.
  - Decrement the counter. After the BIN_W-th iteration, go to DONE.
- DONE:
  - Drive binary_out = bin_acc and done=1 for exactly one cycle; busy=0 in this cycle.
  - Return to IDLE.
- Latency: start sampled at edge N; done=1 in the cycle after edge N+BIN_W+1.
  - Defaults: done is high in cycle 12 after start, counting the start cycle as cycle 0.
  - busy is high for BIN_W cycles.
- binary_out holds its last result until the next DONE. It is not cleared by start.
- start while busy or in DONE is ignored; requests are not queued.
- start held continuously: a new conversion is accepted in each IDLE cycle, i.e. back-to-back every BIN_W+2 cycles.
- bcd_in is sampled only at acceptance; later changes have no effect on the conversion in flight.
- Arithmetic: for valid digits, binary_out = sum of digit_k*10^k exactly; there is no truncation with legal parameters.
- Reset mid-conversion: the next edge with reset=1 returns the FSM to IDLE and clears all outputs. No done pulse is produced.

Optional Feature:
Macro BCD2BIN_CHECK_EN.
- Defined:
  - At acceptance, any digit greater than 9 aborts the request: no SHIFT, FSM goes straight to DONE.
  - In DONE: done=1 and err=1, and binary_out keeps its previous value.
  - err is a one-cycle pulse coincident with done, and is 0 otherwise.
- Not defined:
  - err is tied to 0.
  - Digits greater than 9 are converted anyway; the result is unspecified and must not be checked.
  - Timing is identical to a valid conversion.

Test Plan:
- Reset, then bcd_in=12'h255, start pulse -> busy for 10 cycles, then done for 1 cycle with binary_out=255 (0x0FF), err=0.
- bcd_in=12'h999 -> binary_out=999 (0x3E7); bcd_in=12'h000 -> binary_out=0; done exactly 12 cycles after start in both cases.
- Accept 12'h128, pulse start again at cycle 4 with bcd_in=12'h777 -> second start ignored; single done with binary_out=128; binary_out still 128 for 5 idle cycles afterwards.
- start held high with bcd_in alternating 12'h042 / 12'h310 at each acceptance -> back-to-back done pulses every 12 cycles with 42 then 310.
- Assert reset at cycle 5 of a 12'h500 conversion -> busy=0, done never pulses, binary_out=0; a new start with 12'h007 then yields 7.
- With BCD2BIN_CHECK_EN defined, bcd_in=12'h1A3 -> done and err high in the cycle after acceptance, binary_out unchanged; 12'h103 afterwards -> 103, err=0.

Source files
------------

// File: rtl/bcd_to_binary_seq_if.sv
// Handshake and data bundle between a BCD source and the sequential BCD-to-binary converter.
// Latency: none; this is a plain signal bundle.
// Backpressure: none; the master must watch busy/done, because a start raised while busy is dropped.
interface bcd_to_binary_seq_if #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BIN_W-1:0]      binary_out;

  // Requester side: drives the request and the BCD operand.
  modport master (
    output start, bcd_in,
    input  busy, done, err, binary_out
  );

  // Converter side: consumes the request and reports the result.
  modport slave (
    input  start, bcd_in,
    output busy, done, err, binary_out
  );
endinterface

// File: rtl/bcd_to_binary_seq.sv
// Sequential BCD-to-binary converter using reverse double-dabble: shift right, then subtract 3 from each digit >= 8.
// Latency: start is accepted at edge N and done pulses in the cycle after edge N+BIN_W+1. Busy stays high for BIN_W cycles.
// Backpressure: start is sampled only in IDLE and is ignored otherwise, with no queueing. Optional check macro: BCD2BIN_CHECK_EN.
//
// Legal parameters need 10**DIGITS-1 < 2**BIN_W. BIN_W also sets the number of shift iterations.
// If BCD2BIN_CHECK_EN is defined, a request with any digit above 9 is aborted. In that case done and err
// pulse together in the cycle right after acceptance, and binary_out keeps its previous value.
module bcd_to_binary_seq #(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_to_binary_seq_if.slave   bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * DIGITS;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BCD_W-1:0]   bcd_q, bcd_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic [BIN_W-1:0]   bout_q, bout_d;

  // One reverse double-dabble step on the current {bcd, acc} pair.
  logic [BCD_W+BIN_W-1:0] sh;
  logic [BCD_W-1:0]       adj_bcd;

  // Shift right by one, then correct each digit that came out as 8 or more.
  always_comb begin
    sh      = {bcd_q, acc_q} >> 1;
    adj_bcd = sh[BCD_W+BIN_W-1:BIN_W];
    for (int k = 0; k < DIGITS; k++) begin
      if (adj_bcd[4*k +: 4] >= 4'd8) begin
        adj_bcd[4*k +: 4] = adj_bcd[4*k +: 4] - 4'd3;
      end
    end
  end

  // Invalid-digit detection on the incoming operand. It exists only when checking is compiled in.
  logic bad_digit;
`ifdef BCD2BIN_CHECK_EN
  // Flag any digit above 9 in the operand that is presented at acceptance.
  always_comb begin
    bad_digit = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (bus.bcd_in[4*k +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end
`else
  assign bad_digit = 1'b0;
`endif

  // Next-state logic and datapath updates for the IDLE/SHIFT/DONE sequence.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bcd_d   = bcd_q;
    acc_d   = acc_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    bout_d  = bout_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          bcd_d = bus.bcd_in;
          acc_d = '0;
          if (bad_digit) begin
            // Abort path: report at once and skip the shift loop entirely.
            state_d = DONE;
            cnt_d   = '0;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d = SHIFT;
            cnt_d   = CNT_W'(BIN_W);
          end
        end
      end

      SHIFT: begin
        bcd_d = adj_bcd;
        acc_d = sh[BIN_W-1:0];
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end

      DONE: begin
        state_d = IDLE;
        // An aborted request has already pulsed done/err. Only a real conversion publishes here.
        if (!err_q) begin
          done_d = 1'b1;
          bout_d = acc_q;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bcd_q   <= '0;
      acc_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      bout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcd_q   <= bcd_d;
      acc_q   <= acc_d;
      done_q  <= done_d;
      err_q   <= err_d;
      bout_q  <= bout_d;
    end
  end

  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.binary_out = bout_q;

endmodule
